tail_light_ctrl: RTL
====================

# tail_light_ctrl

Sequencing controller for the rear turn/hazard lamps. It converts driver lever and switch inputs into a latched signalling mode and arbitrates between hazard, left, right and idle. It generates the animation step rate from `clk` and drives the 3-lamp left/right banks with the standard sweep patterns. It sits between the cabin switch inputs and the lamp drivers.

## Interface
- `TICK_DIV`, 4: `clk` cycles per animation step; legal range ≥1.
- `CANCEL_CYCLES`, 8: number of completed turn sweeps before the turn latch self-cancels; 0 disables self-cancel.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: reset. Synchronous and active-high.
- `lt_req` input 1: left lever level.
- `rt_req` input 1: right lever level.
- `haz_req` input 1: hazard switch level.
- `cancel` input 1: one-cycle pulse; clears the turn latch.
- `brake` input 1: brake pedal level. Present only with `TAIL_LIGHT_BRAKE_EN`.
- `li` output 3: left lamp bank. Bit 2 is the innermost lamp.
- `ri` output 3: right lamp bank. Bit 0 is the innermost lamp.
- `mode` output 2: active mode. IDLE=0, LEFT=1, RIGHT=2, HAZ=3.

## Operation
- Turn latch holds IDLE, LEFT or RIGHT. It is updated by rising edges: `x & ~x_q`, where `x_q` is the input registered on the previous cycle.
  - Left edge: IDLE/RIGHT→LEFT; LEFT→IDLE (toggle).
  - Right edge: symmetric to left.
  - Left and right edges in the same cycle: ignored; latch unchanged.
  - `cancel`=1: latch→IDLE. `cancel` wins over a simultaneous lever edge.
- Arbitration: `mode` = HAZ while `haz_req`=1; otherwise `mode` = turn latch. The turn latch keeps updating during HAZ. On `haz_req` release, `mode` returns to the current latch value.
- Prescaler counts 0..TICK_DIV-1. `tick` is asserted at TICK_DIV-1, and the prescaler then wraps to 0.
- Step counter advances on `tick`:
  - LEFT/RIGHT: 0..3, wrapping to 0.
  - HAZ: 0..5, wrapping to 0.
  - IDLE: held at 0.
- Any change of `mode`: step←0 and prescaler←0 on the same edge.
- Patterns, given as `li`/`ri` per step:
  - LEFT: 000/000, 100/000, 110/000, 111/000.
  - RIGHT: 000/000, 000/001, 000/011, 000/111.
  - HAZ: 000/000, 100/001, 110/011, 111/111, 110/011, 100/001.
  - IDLE: 000/000.
- Self-cancel:
  - Sweep counter increments on each LEFT/RIGHT step 3→0 wrap.
  - When it reaches CANCEL_CYCLES, the latch→IDLE.
  - The counter clears on any latch change.
  - While `mode`=HAZ, the counter is frozen.
- Reset mid-operation returns everything to the reset state regardless of the current step.

## Timing
- Reset values: `li`=000, `ri`=000, `mode`=IDLE, latch IDLE, step 0, prescaler 0, sweep counter 0, all `*_q`=0.
  - Because `*_q`=0, a lever held high through reset release produces an edge on the first cycle after reset.
- Lever edge to `mode`: `lt_req` rising at edge N is sampled at N. `x_q` is set at N. `mode` changes at edge N+1.
- `haz_req` to `mode`: 1 cycle latency (registered).
- `li`/`ri` are registered and decoded from the next-state mode/step, so they change on the same edge as `mode`/step. The first lit step appears TICK_DIV cycles after the `mode` change.
- A full turn sweep takes 4·TICK_DIV cycles. A full hazard sweep takes 6·TICK_DIV cycles.
- Self-cancel: the latch reaches IDLE on the edge of the CANCEL_CYCLES-th wrap. The outputs show 000/000 on that same edge.

## Configuration
- `TAIL_LIGHT_BRAKE_EN` defined:
  - `brake` port exists.
  - With `brake`=1 in IDLE: both banks are 111.
  - With `brake`=1 in LEFT: `ri`=111 while `li` keeps animating. RIGHT is symmetric.
  - In HAZ, `brake` is ignored.
  - `brake` affects outputs with 1 cycle latency (registered) and does not reset step or prescaler.
- Not defined: no `brake` port; the output patterns are exactly those listed under Operation.

## Structure
- `tail_light_pkg` contains:
  - the `mode` enum (IDLE/LEFT/RIGHT/HAZ);
  - step-count constants (4, 6);
  - the pattern constant arrays for turn and hazard.
- One sub-module, `tl_step_timer`:
  - holds the prescaler and step counter;
  - inputs: `clk`, `rst`, `restart`, step limit;
  - outputs: step, `wrap`.
  - `tail_light_ctrl` holds the latch, arbitration, self-cancel counter and output decode.

## Test plan
All scenarios use TICK_DIV=2 and CANCEL_CYCLES=2.
- Reset, then idle for 20 cycles → `li`=`ri`=000 and `mode`=0 throughout.
- Left edge → `mode`=1 one edge later. `li` goes 000,100,110,111 with each value held for 2 cycles. After the 2nd wrap (16 cycles after `mode`=1), `mode`=0 and `li`=000.
- Right edge during a LEFT sweep at step 2 → `mode`=2, step restarts at 0, and `li` is 000 on the switch edge.
- `haz_req` high during RIGHT → `mode`=3, six-step mirrored pattern with 111/111 at step 3. Releasing `haz_req` → `mode`=2 and step 0.
- Left and right edges in the same cycle, then `cancel` together with a left edge → `mode` stays 0 in both cases.
- With `TAIL_LIGHT_BRAKE_EN`: `brake`=1 in LEFT → `ri`=111 and `li` keeps animating. `brake`=1 in HAZ → hazard pattern unchanged.

Source files
------------

// File: rtl/tail_light_pkg.sv
// Shared types and constants for the rear turn/hazard lamp sequencer.
package tail_light_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE  = 2'd0,
    MODE_LEFT  = 2'd1,
    MODE_RIGHT = 2'd2,
    MODE_HAZ   = 2'd3
  } mode_e;

  localparam int STEP_W = 3;

  // Number of animation steps in one turn sweep and one hazard sweep.
  localparam logic [STEP_W-1:0] TURN_STEPS = 3'd4;
  localparam logic [STEP_W-1:0] HAZ_STEPS  = 3'd6;

  // Patterns in left-bank orientation (bit 2 innermost); the right bank is the mirror.
  localparam logic [2:0] TURN_PAT [4] = '{3'b000, 3'b100, 3'b110, 3'b111};
  // Padded to 8 entries so the full step value indexes it directly.
  localparam logic [2:0] HAZ_PAT  [8] = '{3'b000, 3'b100, 3'b110, 3'b111,
                                          3'b110, 3'b100, 3'b000, 3'b000};

  // Convert a left-bank pattern to the right bank (innermost lamp is bit 0 there).
  function automatic logic [2:0] mirror3(input logic [2:0] v);
    return {v[0], v[1], v[2]};
  endfunction

endpackage

// File: rtl/tl_step_timer.sv
// Animation timer: prescaler producing a step tick every TICK_DIV cycles and a
// step counter that wraps at a caller-supplied limit.
module tl_step_timer
  import tail_light_pkg::*;
#(
  parameter int TICK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              restart,
  input  logic [STEP_W-1:0] limit,
  output logic [STEP_W-1:0] step_nx,
  output logic              wrap
);

  localparam int            PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  logic [PW-1:0]     presc_q, presc_nx;
  logic [STEP_W-1:0] step_q;
  logic              tick, last;

  // Next prescaler/step values; a restart forces both back to zero.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    tick     = (presc_q == PMAX);
    last     = (step_q == limit - 1'b1);
    wrap     = tick && last;
    presc_nx = tick ? '0 : presc_q + 1'b1;
    step_nx  = step_q;
    if (restart) begin
      presc_nx = '0;
      step_nx  = '0;
    end else if (tick) begin
      step_nx = last ? '0 : step_q + 1'b1;
    end
  end

  // Prescaler and step registers.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      presc_q <= '0;
      step_q  <= '0;
    end else begin
      presc_q <= presc_nx;
      step_q  <= step_nx;
    end
  end

endmodule

// File: rtl/tail_light_ctrl.sv
// Rear turn/hazard lamp sequencer: lever edge latch, hazard arbitration,
// turn self-cancel and registered lamp pattern decode.
// Optional feature: define TAIL_LIGHT_BRAKE_EN to add the brake input, which
// lights the non-animating bank(s) solid outside hazard mode.
module tail_light_ctrl
  import tail_light_pkg::*;
#(
  parameter int TICK_DIV      = 4,
  parameter int CANCEL_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lt_req,
  input  logic       rt_req,
  input  logic       haz_req,
  input  logic       cancel,
`ifdef TAIL_LIGHT_BRAKE_EN
  input  logic       brake,
`endif
  output logic [2:0] li,
  output logic [2:0] ri,
  output logic [1:0] mode
);

  localparam int            CW      = (CANCEL_CYCLES > 1) ? $clog2(CANCEL_CYCLES) : 1;
  localparam bit            SC_EN   = (CANCEL_CYCLES > 0);
  localparam logic [CW-1:0] SC_LAST = CW'(CANCEL_CYCLES - 1);

  logic              lt_q, rt_q;
  mode_e             latch_q, latch_nx;
  mode_e             mode_q, mode_nx;
  logic [CW-1:0]     sweep_q, sweep_nx;
  logic [2:0]        li_nx, ri_nx;
  logic              lt_edge, rt_edge, turn_active, sc_fire, restart, wrap;
  logic [STEP_W-1:0] limit, step_nx;

  tl_step_timer #(.TICK_DIV(TICK_DIV)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .limit   (limit),
    .step_nx (step_nx),
    .wrap    (wrap)
  );

  // Turn latch, arbitration and self-cancel bookkeeping.
  always_comb begin
    lt_edge     = lt_req & ~lt_q;
    rt_edge     = rt_req & ~rt_q;
    turn_active = (mode_q == MODE_LEFT) || (mode_q == MODE_RIGHT);
    sc_fire     = SC_EN && turn_active && wrap && (sweep_q == SC_LAST);

    latch_nx = latch_q;
    if (cancel || sc_fire) begin
      latch_nx = MODE_IDLE;
    end else if (lt_edge && !rt_edge) begin
      latch_nx = (latch_q == MODE_LEFT) ? MODE_IDLE : MODE_LEFT;
    end else if (rt_edge && !lt_edge) begin
      latch_nx = (latch_q == MODE_RIGHT) ? MODE_IDLE : MODE_RIGHT;
    end

    // Self-cancel blanks the lamps on the wrap edge itself; lever changes show a cycle later.
    if (haz_req)      mode_nx = MODE_HAZ;
    else if (sc_fire) mode_nx = MODE_IDLE;
    else              mode_nx = latch_q;

    restart = (mode_nx != mode_q);

    if (mode_q == MODE_HAZ) limit = HAZ_STEPS;
    else if (turn_active)   limit = TURN_STEPS;
    else                    limit = 3'd1;

    // Sweep count is frozen in hazard mode because turn_active is false there.
    sweep_nx = sweep_q;
    if (latch_nx != latch_q)      sweep_nx = '0;
    else if (turn_active && wrap) sweep_nx = sweep_q + 1'b1;
  end

  // Lamp pattern for the mode/step that take effect on this edge.
  always_comb begin
    li_nx = 3'b000;
    ri_nx = 3'b000;
    case (mode_nx)
      MODE_LEFT:  li_nx = TURN_PAT[step_nx[1:0]];
      MODE_RIGHT: ri_nx = mirror3(TURN_PAT[step_nx[1:0]]);
      MODE_HAZ: begin
        li_nx = HAZ_PAT[step_nx];
        ri_nx = mirror3(HAZ_PAT[step_nx]);
      end
      default: ;
    endcase
`ifdef TAIL_LIGHT_BRAKE_EN
    if (brake) begin
      case (mode_nx)
        MODE_IDLE: begin
          li_nx = 3'b111;
          ri_nx = 3'b111;
        end
        MODE_LEFT:  ri_nx = 3'b111;
        MODE_RIGHT: li_nx = 3'b111;
        default: ;
      endcase
    end
`endif
  end

  // Control state and registered lamp outputs.
  always_ff @(posedge clk) begin
    // NOTE: every register here is reset, including the lever history, so a lever held through reset reads as a fresh edge.
    if (rst) begin
      lt_q    <= 1'b0;
      rt_q    <= 1'b0;
      latch_q <= MODE_IDLE;
      mode_q  <= MODE_IDLE;
      sweep_q <= '0;
      li      <= 3'b000;
      ri      <= 3'b000;
    end else begin
      lt_q    <= lt_req;
      rt_q    <= rt_req;
      latch_q <= latch_nx;
      mode_q  <= mode_nx;
      sweep_q <= sweep_nx;
      li      <= li_nx;
      ri      <= ri_nx;
    end
  end

  assign mode = mode_q;

endmodule
